// File: rtl/decode_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | decode_stage: field split, 32x32 register file, load-use hazard, EX reg  |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module decode_stage #(
    parameter int         NREGS   = 32,
    parameter logic [6:0] NOP_OPC = 7'h7F,
    parameter logic [6:0] LDB_OPC = 7'h10,
    parameter logic [6:0] LDW_OPC = 7'h11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inst,
    input  logic        inst_valid,
    input  logic        enable,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [4:0]  wb_reg,
    input  logic [31:0] wb_data,
    output logic [6:0]  opcode,
    output logic [4:0]  dstout,
    output logic [31:0] src1,
    output logic [31:0] src2,
    output logic [4:0]  src1_reg,
    output logic [4:0]  src2_reg,
    output logic [9:0]  offsetlo,
    output logic        valid_out,
    output logic        stall_fetch
);

    logic [31:0] r_regs [NREGS];

    logic [6:0]  w_opc;
    logic [4:0]  w_dst;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [9:0]  w_off;
    logic [31:0] w_rd1;
    logic [31:0] w_rd2;
    logic        w_prev_load;
    logic        w_hazard;

    assign w_opc = inst[31:25];
    assign w_dst = inst[24:20];
    assign w_rs1 = inst[19:15];
    assign w_rs2 = inst[14:10];
    assign w_off = inst[9:0];

    // Same-cycle write-back is forwarded so a replayed or concurrent reader sees it.
    always_comb begin
        w_rd1 = r_regs[w_rs1];
        w_rd2 = r_regs[w_rs2];
        if (w_rs1 == 5'd0) begin
            w_rd1 = '0;
        end else if (wb_en && (wb_reg == w_rs1)) begin
            w_rd1 = wb_data;
        end
        if (w_rs2 == 5'd0) begin
            w_rd2 = '0;
        end else if (wb_en && (wb_reg == w_rs2)) begin
            w_rd2 = wb_data;
        end
    end

    assign w_prev_load = valid_out && ((opcode == LDB_OPC) || (opcode == LDW_OPC));
    assign w_hazard    = w_prev_load && (dstout != 5'd0) && inst_valid &&
                         ((dstout == w_rs1) || (dstout == w_rs2));
    assign stall_fetch = w_hazard || !enable;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_en && (wb_reg != 5'd0)) begin
            r_regs[wb_reg] <= wb_data;
        end
    end

    // Bubbles carry zero indices so downstream bypass compares never match.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opcode    <= NOP_OPC;
            dstout    <= '0;
            src1      <= '0;
            src2      <= '0;
            src1_reg  <= '0;
            src2_reg  <= '0;
            offsetlo  <= '0;
            valid_out <= 1'b0;
        end else if (enable) begin
            if (flush || w_hazard || !inst_valid) begin
                opcode    <= NOP_OPC;
                dstout    <= '0;
                src1      <= '0;
                src2      <= '0;
                src1_reg  <= '0;
                src2_reg  <= '0;
                offsetlo  <= '0;
                valid_out <= 1'b0;
            end else begin
                opcode    <= w_opc;
                dstout    <= w_dst;
                src1      <= w_rd1;
                src2      <= w_rd2;
                src1_reg  <= w_rs1;
                src2_reg  <= w_rs2;
                offsetlo  <= w_off;
                valid_out <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_decode_stage: scoreboard bench with a behavioural decode model        |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_decode_stage;

    localparam logic [6:0] C_NOP = 7'h7F;
    localparam logic [6:0] C_LDB = 7'h10;
    localparam logic [6:0] C_LDW = 7'h11;

    typedef struct packed {
        logic [6:0]  opc;
        logic [4:0]  dst;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [9:0]  off;
        logic        v;
    } out_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] inst;
    logic        inst_valid;
    logic        enable;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic [6:0]  opcode;
    logic [4:0]  dstout;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  src1_reg;
    logic [4:0]  src2_reg;
    logic [9:0]  offsetlo;
    logic        valid_out;
    logic        stall_fetch;

    decode_stage dut (
        .clk(clk), .reset(reset), .inst(inst), .inst_valid(inst_valid),
        .enable(enable), .flush(flush), .wb_en(wb_en), .wb_reg(wb_reg),
        .wb_data(wb_data), .opcode(opcode), .dstout(dstout), .src1(src1),
        .src2(src2), .src1_reg(src1_reg), .src2_reg(src2_reg),
        .offsetlo(offsetlo), .valid_out(valid_out), .stall_fetch(stall_fetch)
    );

    always #5 clk = ~clk;

    int   n_pass  = 0;
    int   n_total = 0;
    out_t q_exp[$];
    out_t m_out;
    logic [31:0] m_regs [32];
    logic m_stall;

    function automatic out_t bubble();
        out_t b;
        b     = '0;
        b.opc = C_NOP;
        return b;
    endfunction

    function automatic logic [31:0] enc(input logic [6:0] o, input logic [4:0] d,
                                        input logic [4:0] a, input logic [4:0] b,
                                        input logic [9:0] off);
        return {o, d, a, b, off};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] idx, input logic we,
                                               input logic [4:0] wr, input logic [31:0] wd);
        if (idx == 5'd0) return 32'd0;
        if (we && wr == idx) return wd;
        return m_regs[idx];
    endfunction

    // One pipeline cycle: drive at negedge, check stall, queue the expected register state.
    task automatic cycle(input logic [31:0] a_inst, input logic a_iv, input logic a_en,
                         input logic a_fl, input logic a_we, input logic [4:0] a_wr,
                         input logic [31:0] a_wd);
        logic hz;
        out_t nxt;
        @(negedge clk);
        inst = a_inst; inst_valid = a_iv; enable = a_en; flush = a_fl;
        wb_en = a_we; wb_reg = a_wr; wb_data = a_wd;
        #1;
        hz = m_out.v && (m_out.opc == C_LDB || m_out.opc == C_LDW) && m_out.dst != 5'd0 &&
             a_iv && (m_out.dst == a_inst[19:15] || m_out.dst == a_inst[14:10]);
        chk("stall_fetch", stall_fetch, hz || !a_en);
        m_stall = hz || !a_en;
        nxt = m_out;
        if (a_en) begin
            if (a_fl || hz || !a_iv) nxt = bubble();
            else begin
                nxt.opc = a_inst[31:25];
                nxt.dst = a_inst[24:20];
                nxt.r1  = a_inst[19:15];
                nxt.r2  = a_inst[14:10];
                nxt.off = a_inst[9:0];
                nxt.s1  = model_read(a_inst[19:15], a_we, a_wr, a_wd);
                nxt.s2  = model_read(a_inst[14:10], a_we, a_wr, a_wd);
                nxt.v   = 1'b1;
            end
        end
        m_out = nxt;
        q_exp.push_back(nxt);
        if (a_we && a_wr != 5'd0) m_regs[a_wr] = a_wd;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic model_reset();
        m_out = bubble();
        m_stall = 1'b0;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        q_exp.delete();
    endtask

    // Monitor: every edge that has a queued expectation is compared.
    initial begin
        out_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                chk("outputs", {opcode, dstout, src1, src2, src1_reg, src2_reg, offsetlo, valid_out}, e);
            end
        end
    end

    initial begin
        logic [31:0] r_inst;
        logic        r_iv;
        reset = 1'b1; inst = '0; inst_valid = 1'b0; enable = 1'b1; flush = 1'b0;
        wb_en = 1'b0; wb_reg = '0; wb_data = '0;
        model_reset();
        #1;
        chk("reset_opcode", opcode, C_NOP);
        chk("reset_valid", valid_out, 1'b0);
        chk("reset_dst", dstout, 5'd0);
        chk("reset_stall", stall_fetch, 1'b0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        // register writes then ADD
        cycle(32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd1, 32'd20);
        cycle(32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd2, 32'd10);
        cycle(enc(7'h00, 5'd3, 5'd1, 5'd2, 10'd0), 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        after_edge();
        chk("add_opcode", opcode, 7'h00);
        chk("add_dst", dstout, 5'd3);
        chk("add_src1", src1, 32'd20);
        chk("add_src2", src2, 32'd10);
        chk("add_valid", valid_out, 1'b1);

        // write-through and r0
        cycle(enc(7'h01, 5'd6, 5'd5, 5'd0, 10'h155), 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 32'hDEAD);
        after_edge();
        chk("wt_src1", src1, 32'hDEAD);
        chk("wt_off", offsetlo, 10'h155);
        cycle(32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 32'd7);
        cycle(enc(7'h01, 5'd6, 5'd0, 5'd5, 10'd0), 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        after_edge();
        chk("r0_read", src1, 32'd0);
        chk("r5_read", src2, 32'hDEAD);

        // load-use: one bubble, replay passes; write-back during the stall is seen on replay
        cycle(enc(C_LDW, 5'd4, 5'd1, 5'd2, 10'd0), 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        cycle(enc(7'h02, 5'd7, 5'd4, 5'd2, 10'd0), 1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 32'h1234);
        chk("lu_stall", stall_fetch, 1'b1);
        after_edge();
        chk("lu_bubble_opc", opcode, C_NOP);
        chk("lu_bubble_valid", valid_out, 1'b0);
        cycle(enc(7'h02, 5'd7, 5'd4, 5'd2, 10'd0), 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("lu_replay_stall", stall_fetch, 1'b0);
        after_edge();
        chk("lu_replay_opc", opcode, 7'h02);
        chk("lu_replay_valid", valid_out, 1'b1);
        chk("lu_replay_src1", src1, 32'h1234);
        cycle(enc(C_LDB, 5'd4, 5'd1, 5'd2, 10'd0), 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        cycle(enc(7'h02, 5'd7, 5'd6, 5'd2, 10'd0), 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("no_hazard_stall", stall_fetch, 1'b0);

        // enable low freezes outputs
        cycle(enc(7'h00, 5'd3, 5'd1, 5'd2, 10'd0), 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            cycle(enc(7'h05, 5'(k + 8), 5'd2, 5'd1, 10'(k)), 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
            chk("hold_stall", stall_fetch, 1'b1);
            after_edge();
            chk("hold_opc", opcode, 7'h00);
            chk("hold_dst", dstout, 5'd3);
        end
        cycle(enc(7'h05, 5'd9, 5'd1, 5'd1, 10'd0), 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        after_edge();
        chk("release_opc", opcode, 7'h05);
        chk("release_src1", src1, 32'd20);

        // flush, and flush with hazard
        cycle(enc(7'h00, 5'd3, 5'd1, 5'd2, 10'd3), 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
        after_edge();
        chk("flush_opc", opcode, C_NOP);
        chk("flush_dst", dstout, 5'd0);
        cycle(enc(C_LDW, 5'd4, 5'd1, 5'd2, 10'd0), 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        cycle(enc(7'h02, 5'd7, 5'd4, 5'd2, 10'd0), 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
        chk("flush_hz_stall", stall_fetch, 1'b1);
        after_edge();
        chk("flush_hz_valid", valid_out, 1'b0);

        // async reset while held
        cycle(enc(7'h00, 5'd3, 5'd1, 5'd2, 10'd0), 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        cycle(enc(7'h05, 5'd3, 5'd1, 5'd2, 10'd0), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_opc", opcode, C_NOP);
        chk("async_valid", valid_out, 1'b0);
        chk("async_src1", src1, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        cycle(enc(7'h00, 5'd3, 5'd1, 5'd2, 10'd0), 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        after_edge();
        chk("post_reset_r1", src1, 32'd0);
        chk("post_reset_valid", valid_out, 1'b1);

        // randomized traffic; fetch holds its instruction while stalled
        r_inst = '0;
        r_iv   = 1'b0;
        for (int n = 0; n < 400; n++) begin
            logic [6:0] o;
            if (!m_stall) begin
                case ($urandom_range(0, 3))
                    0: o = C_LDB;
                    1: o = C_LDW;
                    default: o = 7'($urandom);
                endcase
                r_inst = enc(o, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                             5'($urandom_range(0, 7)), 10'($urandom));
                r_iv = ($urandom_range(0, 99) < 85);
            end
            cycle(r_inst, r_iv, $urandom_range(0, 99) < 80, $urandom_range(0, 99) < 10,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
        end
        after_edge();
        chk("queue_drained", q_exp.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Decode stage feeding the Execution stage of the 5-stage pipeline.
- Splits the fetched instruction into fields, reads the 32x32 register file (written back by WB), detects load-use hazards, and registers opcode/dst/operands/offset for Execution.
- Inserts bubbles on hazard, flush or reset.
- Holds its output register while downstream disables it.

Parameters:
- NREGS, 32, number of architectural registers (index width 5).
- NOP_OPC, 7'h7F, opcode driven for a bubble.
- LDB_OPC, 7'h10, load-byte opcode (hazard source).
- LDW_OPC, 7'h11, load-word opcode (hazard source).

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high.
- inst  in  32  fetched instruction.
- inst_valid  in  1  inst holds a real instruction.
- enable  in  1  downstream ready; 0 = hold all outputs.
- flush  in  1  taken branch/exception; kill the instruction in decode.
- wb_en  in  1  register-file write enable.
- wb_reg  in  5  write-back register index.
- wb_data  in  32  write-back data.
- opcode  out  7  to Execution.
- dstout  out  5  destination register.
- src1, src2  out  32  operand values.
- src1_reg, src2_reg  out  5  operand indices (Execution uses these for bypass compare).
- offsetlo  out  10  immediate.
- valid_out  out  1  registered instruction is real (0 = bubble).
- stall_fetch  out  1  combinational; fetch must hold PC and inst.

Behaviour:
- Encoding:
  - inst[31:25] opcode
  - inst[24:20] dst
  - inst[19:15] src1 index
  - inst[14:10] src2 index
  - inst[9:0] offsetlo
- Register file:
  - r0 reads 0; writes to r0 are ignored.
  - Write on posedge when wb_en=1.
  - Write-through: if wb_en=1, wb_reg!=0 and wb_reg equals a read index in the same cycle, that read returns wb_data.
- Reset (async):
  - All output registers clear: opcode=NOP_OPC, valid_out=0, everything else 0.
  - Register file clears to 0.
  - Reset mid-stall discards the held instruction.
- Hazard:
  - hazard = valid_out & (opcode==LDB_OPC | opcode==LDW_OPC) & dstout!=0 & inst_valid & (dstout==inst[19:15] | dstout==inst[14:10]).
  - stall_fetch = hazard | ~enable.
- Output register update at posedge, priority high to low:
  1. enable=0: hold every output; flush is ignored (branch unit re-asserts flush).
  2. flush=1: load a bubble (opcode=NOP_OPC, valid_out=0, dst/regs/offset=0).
  3. hazard=1: load a bubble. The same inst is presented next cycle and passes.
  4. inst_valid=0: load a bubble.
  5. Otherwise: load the decoded fields and register-file values; valid_out=1.
- Latency: 1 cycle inst -> outputs. A load-use pair costs exactly 1 bubble.
- A hazard never lasts more than 1 cycle, because the load leaves the output register.
- Bubble fields are zero so Execution bypass compares cannot match a real register.
- WB write and a hazard in the same cycle: the write still completes; on replay the instruction reads the new value.

Test Plan:
- Reset then wb_en writes r1=20, r2=10. Then inst ADD (opc 00, dst 3, s1 1, s2 2) -> next cycle: opcode=00, dstout=3, src1=20, src2=10, valid_out=1.
- Write-through: wb_en=1, wb_reg=5, wb_data=0xDEAD in the same cycle as an inst reading r5 -> src1=0xDEAD. Reading r0 after writing r0=7 -> 0.
- Load-use: LDW dst 4, then SUB s1=4 ->
  - stall_fetch=1 for one cycle, one bubble (opcode=7F, valid_out=0);
  - then SUB issues with valid_out=1.
  - SUB using r6 instead of r4 -> no stall.
- enable=0 for 3 cycles with a changing inst -> outputs frozen, stall_fetch=1; on release the pending inst issues.
- flush during a valid ADD -> bubble next cycle. flush and hazard together -> bubble, with stall_fetch=1 that cycle.
- Assert reset mid-stream while enable=0 -> outputs immediately bubble/0 without a clock edge. After release, a read of r1 returns 0.
